// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feed sequencer.
// The window test is shared by the lane muxes and the PE enable decode.
package systolic_pkg;

  localparam int DEFAULT_N  = 3;
  localparam int DEFAULT_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Signed int arguments keep t < base from aliasing into a valid index
  function automatic logic in_window(input int t, input int base, input int n);
    return (t >= base) && (t <= base + n - 1);
  endfunction

endpackage

// File: rtl/systolic_skew_sel.sv
// Per-lane skew mux: lane l carries element [l][t-l] of the latched matrix, or
// element [t-l][l] when TRANSPOSE is set; lanes outside their window carry zero.
module systolic_skew_sel
  import systolic_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int DW        = DEFAULT_DW,
  parameter int TW        = 3,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic [N*N*DW-1:0] mat,
  input  logic [TW-1:0]     step,
  output logic [N*DW-1:0]   lanes
);

  always_comb begin
    lanes = '0;
    for (int lane = 0; lane < N; lane++) begin
      if (in_window(int'(step), lane, N)) begin
        if (TRANSPOSE)
          lanes[lane*DW +: DW] = mat[((int'(step) - lane) * N + lane) * DW +: DW];
        else
          lanes[lane*DW +: DW] = mat[(lane * N + int'(step) - lane) * DW +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: latches operands, clears
// the PEs, streams skewed A rows / B columns with per-PE enables, then pulses DONE.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int DW       = DEFAULT_DW,
  parameter int PIPE_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [N*N*DW-1:0] A_FLAT,
  input  logic [N*N*DW-1:0] B_FLAT,
  output logic [N*DW-1:0]   A_ROW_OUT,
  output logic [N*DW-1:0]   B_COL_OUT,
  output logic [N*N-1:0]    PE_EN,
  output logic              PE_CLR,
  output logic              BUSY,
  output logic              DONE
);

  localparam int TW        = $clog2(3 * N - 1);
  localparam int LAST_STEP = 3 * N - 3;
  localparam int DRW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t            state, state_next;
  logic [TW-1:0]     step;
  logic [DRW-1:0]    drain_cnt;
  logic [N*N*DW-1:0] a_lat, b_lat;
  logic [N*DW-1:0]   a_lanes, b_lanes;
  logic              accept;

  logic [N*DW-1:0]   a_row_d, b_col_d;
  logic [N*N-1:0]    pe_en_d;
  logic              pe_clr_d, busy_d, done_d;

  // The DONE state is referenced through the package because the DONE port shadows it
  assign accept = START && (state == IDLE || state == systolic_pkg::DONE);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      step      <= '0;
      drain_cnt <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
    end else begin
      if (accept) begin
        a_lat <= A_FLAT;
        b_lat <= B_FLAT;
      end
      step      <= (state == FEED && step != TW'(LAST_STEP)) ? step + 1'b1 : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:               if (START) state_next = CLEAR;
      CLEAR:              state_next = FEED;
      FEED:               if (step == TW'(LAST_STEP)) state_next = DRAIN;
      DRAIN:              if (drain_cnt == DRW'(PIPE_LAT - 1)) state_next = systolic_pkg::DONE;
      systolic_pkg::DONE: state_next = START ? CLEAR : IDLE;
      default:            state_next = IDLE;
    endcase
  end

  systolic_skew_sel #(.N(N), .DW(DW), .TW(TW), .TRANSPOSE(1'b0)) u_a_sel (
    .mat   (a_lat),
    .step  (step),
    .lanes (a_lanes)
  );

  systolic_skew_sel #(.N(N), .DW(DW), .TW(TW), .TRANSPOSE(1'b1)) u_b_sel (
    .mat   (b_lat),
    .step  (step),
    .lanes (b_lanes)
  );

  // Output values for the current state; registered below so every port is a flop
  always_comb begin
    a_row_d  = '0;
    b_col_d  = '0;
    pe_en_d  = '0;
    pe_clr_d = (state == CLEAR);
    busy_d   = (state == CLEAR) || (state == FEED) || (state == DRAIN);
    done_d   = (state == systolic_pkg::DONE);
    if (state == FEED) begin
      a_row_d = a_lanes;
      b_col_d = b_lanes;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          pe_en_d[i*N+j] = in_window(int'(step), i + j, N);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      A_ROW_OUT <= '0;
      B_COL_OUT <= '0;
      PE_EN     <= '0;
      PE_CLR    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      A_ROW_OUT <= a_row_d;
      B_COL_OUT <= b_col_d;
      PE_EN     <= pe_en_d;
      PE_CLR    <= pe_clr_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl: a run-timeline model checked every cycle,
// directed scenarios pinned with hand-computed values, then randomized traffic.
module tb_systolic_feed_ctrl;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int PL = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [N*N*DW-1:0] a_flat = '0;
  logic [N*N*DW-1:0] b_flat = '0;
  logic [N*DW-1:0]   a_row_out, b_col_out;
  logic [N*N-1:0]    pe_en;
  logic              pe_clr, busy, done;

  systolic_feed_ctrl #(.N(N), .DW(DW), .PIPE_LAT(PL)) dut (
    .CLK       (clk),
    .RESET     (reset),
    .START     (start),
    .A_FLAT    (a_flat),
    .B_FLAT    (b_flat),
    .A_ROW_OUT (a_row_out),
    .B_COL_OUT (b_col_out),
    .PE_EN     (pe_en),
    .PE_CLR    (pe_clr),
    .BUSY      (busy),
    .DONE      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Run timeline model: a run accepted at edge E clears in E+1, feeds step t in E+2+t,
  // and signals DONE in E+3N+PL; the next START is honoured from that same edge on.
  longint cyc = 0;
  longint ready_edge = 0;
  longint run_start = 0;
  longint done_a = -1, done_b = -1;
  bit     run_active = 0;
  bit     model_valid = 0;
  logic [DW-1:0] am [N][N];
  logic [DW-1:0] bm [N][N];

  logic [N*DW-1:0] exp_a, exp_b;
  logic [N*N-1:0]  exp_en;
  logic            exp_clr, exp_busy, exp_done;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_valid = 1;
      run_active  = 0;
      done_a      = -1;
      done_b      = -1;
      ready_edge  = cyc + 1;
    end else if (start && cyc >= ready_edge) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          am[i][k] = a_flat[(i*N+k)*DW +: DW];
          bm[i][k] = b_flat[(i*N+k)*DW +: DW];
        end
      run_active = 1;
      run_start  = cyc;
      done_b     = done_a;
      done_a     = cyc + 3*N + PL;
      ready_edge = cyc + 3*N + PL;
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      longint d, t;
      exp_a = '0; exp_b = '0; exp_en = '0;
      exp_clr = 0; exp_busy = 0;
      if (run_active) begin
        d = cyc - run_start;
        t = d - 2;
        exp_clr  = (d == 1);
        exp_busy = (d >= 1) && (d <= 3*N + PL - 1);
        if (t >= 0 && t <= 3*N - 3) begin
          for (int l = 0; l < N; l++) begin
            if (t - l >= 0 && t - l < N) begin
              exp_a[l*DW +: DW] = am[l][t-l];
              exp_b[l*DW +: DW] = bm[t-l][l];
            end
          end
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              exp_en[i*N+j] = (t >= i + j) && (t < i + j + N);
        end
      end
      exp_done = (cyc == done_a) || (cyc == done_b);
      check_output("a_row", a_row_out, exp_a);
      check_output("b_col", b_col_out, exp_b);
      check_output("pe_en", pe_en, exp_en);
      check_output("pe_clr", pe_clr, exp_clr);
      check_output("busy", busy, exp_busy);
      check_output("done", done, exp_done);
    end
  end

  int lit_lane0 [7] = '{1, 2, 3, 0, 0, 0, 0};
  int lit_lane2 [7] = '{0, 0, 7, 8, 9, 0, 0};
  int lit_pop   [7] = '{1, 3, 6, 7, 6, 3, 1};

  // Settle a little after the falling edge so the per-cycle compare has already run
  task automatic wait_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic apply_stimulus_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_flat[(i*N+k)*DW +: DW] = DW'(i*N + k + 1);
        b_flat[(i*N+k)*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
      end
  endtask

  task automatic apply_stimulus_random();
    for (int e = 0; e < N*N; e++) begin
      a_flat[e*DW +: DW] = DW'($urandom_range(0, 255));
      b_flat[e*DW +: DW] = DW'($urandom_range(0, 255));
    end
  endtask

  task automatic run_identity_check();
    apply_stimulus_identity();
    start = 1;
    wait_cycle();
    start = 0;
    wait_cycle();
    check_output("clr_cycle1", pe_clr, 1);
    check_output("model_clr_cycle1", exp_clr, 1);
    for (int t = 0; t < 7; t++) begin
      wait_cycle();
      check_output($sformatf("lane0_t%0d", t), a_row_out[0 +: DW], lit_lane0[t]);
      check_output($sformatf("lane2_t%0d", t), a_row_out[2*DW +: DW], lit_lane2[t]);
      check_output($sformatf("model_lane2_t%0d", t), exp_a[2*DW +: DW], lit_lane2[t]);
      check_output($sformatf("pop_t%0d", t), $countones(pe_en), lit_pop[t]);
      check_output($sformatf("model_pop_t%0d", t), $countones(exp_en), lit_pop[t]);
      check_output($sformatf("en0_t%0d", t), pe_en[0], t <= 2);
      check_output($sformatf("en8_t%0d", t), pe_en[8], t >= 4);
    end
    wait_cycle();
    check_output("done_cycle9", done, 0);
    wait_cycle();
    check_output("done_cycle10", done, 1);
    check_output("model_done_cycle10", exp_done, 1);
    wait_cycle();
    check_output("done_cycle11", done, 0);
  endtask

  initial begin
    reset = 1;
    repeat (3) wait_cycle();
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_clr", pe_clr, 0);
    check_output("reset_en", pe_en, 0);
    check_output("reset_lanes", {a_row_out, b_col_out}, 0);
    start = 1;
    #1;
    check_output("start_no_edge_busy", busy, 0);
    check_output("start_no_edge_clr", pe_clr, 0);
    start = 0;
    wait_cycle();
    reset = 0;
    wait_cycle();

    $display("[TB] identity run");
    run_identity_check();
    repeat (2) wait_cycle();

    $display("[TB] back-to-back runs with START held");
    apply_stimulus_identity();
    start = 1;
    wait_cycle();
    for (int d = 1; d <= 20; d++) begin
      wait_cycle();
      if (d == 4) begin
        check_output("hold_lane0_t2", a_row_out[0 +: DW], 3);
        apply_stimulus_random();
      end
      if (d == 5) check_output("hold_lane2_t3", a_row_out[2*DW +: DW], 8);
      if (d == 10) check_output("hold_done10", done, 1);
      if (d == 11) check_output("hold_clr11", pe_clr, 1);
      if (d == 19) start = 0;
      if (d == 20) check_output("hold_done20", done, 1);
    end
    repeat (3) wait_cycle();

    $display("[TB] reset mid-run");
    apply_stimulus_identity();
    start = 1;
    wait_cycle();
    start = 0;
    repeat (5) wait_cycle();
    reset = 1;
    wait_cycle();
    check_output("abort_busy", busy, 0);
    check_output("abort_en", pe_en, 0);
    check_output("abort_lanes", {a_row_out, b_col_out}, 0);
    check_output("abort_done", done, 0);
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      wait_cycle();
      check_output("abort_no_done", done, 0);
    end
    run_identity_check();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      wait_cycle();
      start = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1) apply_stimulus_random();
    end
    start = 0;
    reset = 0;
    repeat (15) wait_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
